y86_pipe_stage: RTL
===================

# y86_pipe_stage

Parametrised pipeline-stage register for the Y86 five-stage pipeline. It replaces the per-stage fixed-field registers (F/D, D/E, E/M, M/W) with one generic block that carries an opaque payload plus a valid bit. It implements stall/bubble control with a fixed priority, keeps saturating stall and bubble statistics for hazard-unit debug, and optionally compiles in a one-entry skid buffer so upstream stalls may lag by a cycle.

## Interface
Parameters:
- DATA_W, 84: payload width (stat, icode, ifun, rA, rB, valC, valP for the D stage).
- BUBBLE_VAL, Y86_D_BUBBLE: payload driven while bubbled or invalid (encodes S_OK, I_NOP, ifun 0, R_NONE, R_NONE, 0, 0).
- CNT_W, 8: width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream word present.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage can accept in_data this cycle.
- stall  in  1  hold the current output.
- bubble  in  1  replace the output with BUBBLE_VAL.
- out_valid  out  1  out_data is a real instruction.
- out_data  out  DATA_W  registered payload.
- stall_cnt  out  CNT_W  consecutive stalled cycles, saturating.
- bubble_cnt  out  CNT_W  bubbles injected since reset, saturating.

## Operation
- Per-edge priority: reset > bubble > stall > load.
- Reset:
  - out_valid=0, out_data=BUBBLE_VAL, stall_cnt=0, bubble_cnt=0.
  - Skid buffer emptied; in_ready=1.
- Bubble (bubble=1, regardless of stall):
  - out_valid=0, out_data=BUBBLE_VAL.
  - Skid buffer flushed.
  - bubble_cnt+1, saturating at 2^CNT_W-1.
  - stall_cnt cleared.
- Stall (stall=1, bubble=0):
  - out_valid and out_data hold.
  - stall_cnt+1, saturating.
- Load (stall=0, bubble=0):
  - If the skid buffer is full, its word loads into the output and the buffer empties.
  - Otherwise out_valid<=in_valid, and out_data<=in_data when in_valid=1, else BUBBLE_VAL.
  - stall_cnt cleared.
- out_data always equals BUBBLE_VAL whenever out_valid=0.
- Counters never wrap. The saturated value holds until the clear condition (for stall_cnt) or reset (for bubble_cnt).

## Timing
- Latency: one cycle from in_data to out_data when not stalled.
- All outputs are registered except in_ready, which is combinational from skid-buffer state only. in_ready has no combinational path from stall or bubble.
- stall and bubble are sampled on the same edge as in_data. Simultaneous stall and bubble gives a bubble.
- Reset asserted mid-stall or with the skid buffer full discards all state on that edge.
- Skid build:
  - Stall released with the skid buffer full: the skid word goes out first. in_ready returns to 1 in the following cycle.
  - In that release cycle, in_ready=0, so upstream must hold in_data.

## Configuration
- Y86_PIPE_SKID_EN defined:
  - One-entry skid buffer is present.
  - With stall=1, bubble=0, in_valid=1, in_ready=1, in_data is captured into the skid buffer and in_ready drops to 0 next cycle.
  - Further words are refused while in_ready=0.
- Y86_PIPE_SKID_EN undefined:
  - No skid storage; in_ready tied to 1.
  - in_data presented during a stall is discarded. Upstream must stall in the same cycle, as the hazard unit does today.

## Structure
- Shared package y86_pipe_pkg holds:
  - Y86 stat/icode/register encodings (S_OK, I_NOP, R_NONE).
  - Per-stage payload widths and bubble constants: Y86_D_BUBBLE, Y86_E_BUBBLE, Y86_M_BUBBLE, Y86_W_BUBBLE.
- Sub-module y86_sat_counter (parameter W; ports inc, clr, cnt), instantiated twice, for stall_cnt and bubble_cnt.

## Test plan
- Reset, then in_valid=1, in_data=0x123 for one cycle -> out_valid=1, out_data=0x123 one edge later; all counters 0.
- Hold stall=1 for 300 cycles with CNT_W=8 -> out_data unchanged; stall_cnt reads 255 and holds; clears to 0 on the first stall=0 edge.
- stall=1 and bubble=1 together -> out_valid=0, out_data=BUBBLE_VAL, bubble_cnt=1, stall_cnt=0.
- With Y86_PIPE_SKID_EN: stall=1, in_data=0xA5 valid -> in_ready=0 next cycle. Release stall -> out_data=0xA5, then in_ready=1 the cycle after.
- With Y86_PIPE_SKID_EN: skid buffer full, then bubble=1 -> buffer flushed, in_ready=1 next cycle, out_valid=0.
- reset=1 while stalled with stall_cnt=40 -> next edge out_valid=0, out_data=BUBBLE_VAL, stall_cnt=0, bubble_cnt=0.

Source files
------------

// File: rtl/y86_pipe_pkg.sv
// ----------------------------------------------------------------------------
// y86_pipe_pkg
// Shared definitions for the Y86 pipeline-register slice:
//   - stat / icode / register-id encodings used to build bubble words
//   - per-stage payload widths and the matching bubble constants for the
//     D, E, M and W pipeline registers (32-bit Y86 datapath, 4-bit fields)
// No ports; imported by y86_sat_counter and y86_pipe_stage.
// ----------------------------------------------------------------------------
package y86_pipe_pkg;

    // Status codes
    localparam logic [3:0] S_OK  = 4'h1;
    localparam logic [3:0] S_HLT = 4'h2;
    localparam logic [3:0] S_ADR = 4'h3;
    localparam logic [3:0] S_INS = 4'h4;

    // Instruction codes used for bubbles
    localparam logic [3:0] I_HALT = 4'h0;
    localparam logic [3:0] I_NOP  = 4'h1;

    // Register id meaning "no register"
    localparam logic [3:0] R_NONE = 4'hF;

    // D stage: stat, icode, ifun, rA, rB, valC, valP
    localparam int Y86_D_W = 4 + 4 + 4 + 4 + 4 + 32 + 32;
    // E stage: stat, icode, ifun, valC, valA, valB, dstE, dstM, srcA, srcB
    localparam int Y86_E_W = 4 + 4 + 4 + 32 + 32 + 32 + 4 + 4 + 4 + 4;
    // M stage: stat, icode, Cnd, valE, valA, dstE, dstM
    localparam int Y86_M_W = 4 + 4 + 1 + 32 + 32 + 4 + 4;
    // W stage: stat, icode, valE, valM, dstE, dstM
    localparam int Y86_W_W = 4 + 4 + 32 + 32 + 4 + 4;

    // Bubble words: a NOP with status OK that writes no register
    localparam logic [Y86_D_W-1:0] Y86_D_BUBBLE =
        {S_OK, I_NOP, 4'h0, R_NONE, R_NONE, 32'h0, 32'h0};
    localparam logic [Y86_E_W-1:0] Y86_E_BUBBLE =
        {S_OK, I_NOP, 4'h0, 32'h0, 32'h0, 32'h0, R_NONE, R_NONE, R_NONE, R_NONE};
    localparam logic [Y86_M_W-1:0] Y86_M_BUBBLE =
        {S_OK, I_NOP, 1'b0, 32'h0, 32'h0, R_NONE, R_NONE};
    localparam logic [Y86_W_W-1:0] Y86_W_BUBBLE =
        {S_OK, I_NOP, 32'h0, 32'h0, R_NONE, R_NONE};

endpackage

// File: rtl/y86_pipe_stage_sat_counter.sv
// ----------------------------------------------------------------------------
// y86_sat_counter
// Saturating up-counter used for the stall and bubble statistics.
// Ports:
//   clk   in   rising-edge clock
//   reset in   synchronous active-high reset, clears the count
//   inc   in   add one unless already at all-ones
//   clr   in   clear to zero (wins over inc)
//   cnt   out  W-bit registered count
// ----------------------------------------------------------------------------
module y86_sat_counter
    import y86_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Count register: once all-ones it sticks there until clr or reset,
    // so a long hazard never wraps back to a small, misleading number.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/y86_pipe_stage.sv
// ----------------------------------------------------------------------------
// y86_pipe_stage
// Generic Y86 pipeline register: opaque payload plus valid bit, with
// stall/bubble control (priority reset > bubble > stall > load) and
// saturating stall/bubble statistics.
//
// Optional feature macro: Y86_PIPE_SKID_EN
//   defined   -> one-entry skid buffer captures a word offered during a stall,
//                so upstream may react to the stall one cycle late
//   undefined -> no skid storage, in_ready tied high, words offered during a
//                stall are dropped
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   in_valid   in   upstream word present
//   in_data    in   upstream payload
//   in_ready   out  stage accepts in_data this cycle (skid state only)
//   stall      in   hold the current output
//   bubble     in   replace the output with BUBBLE_VAL
//   out_valid  out  out_data is a real instruction
//   out_data   out  registered payload (BUBBLE_VAL whenever out_valid=0)
//   stall_cnt  out  consecutive stalled cycles, saturating
//   bubble_cnt out  bubbles injected since reset, saturating
// ----------------------------------------------------------------------------
module y86_pipe_stage
    import y86_pipe_pkg::*;
#(
    parameter int                 DATA_W     = 84,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = Y86_D_BUBBLE,
    parameter int                 CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              stall,
    input  logic              bubble,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

`ifdef Y86_PIPE_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;

    // Ready depends only on the stored skid state, never on stall/bubble,
    // so the upstream handshake has no combinational loop through the
    // hazard unit.
    assign in_ready = ~skid_valid;

    // Skid buffer: park a word that arrives while we are stalled. It is
    // drained on the first non-stalled edge and thrown away by a bubble,
    // since a bubble means the instruction stream behind it is squashed.
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            skid_valid <= 1'b0;
            skid_data  <= BUBBLE_VAL;
        end else if (stall) begin
            if (in_valid && !skid_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end
        end else begin
            skid_valid <= 1'b0;
            skid_data  <= BUBBLE_VAL;
        end
    end
`else
    assign in_ready = 1'b1;
`endif

    // Output register. Invalid slots always carry BUBBLE_VAL so downstream
    // stages can decode a NOP without looking at out_valid.
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            out_valid <= 1'b0;
            out_data  <= BUBBLE_VAL;
        end else if (!stall) begin
`ifdef Y86_PIPE_SKID_EN
            if (skid_valid) begin
                out_valid <= 1'b1;
                out_data  <= skid_data;
            end else
`endif
            begin
                out_valid <= in_valid;
                out_data  <= in_valid ? in_data : BUBBLE_VAL;
            end
        end
    end

    // Stall counter tracks the current run of stalls only; any bubble or
    // load edge ends the run.
    y86_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall & ~bubble),
        .clr   (~stall | bubble),
        .cnt   (stall_cnt)
    );

    // Bubble counter accumulates for the whole run since reset.
    y86_sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bubble),
        .clr   (1'b0),
        .cnt   (bubble_cnt)
    );

endmodule
